imm_extend_pipe: RTL

//  Decode-stage immediate generator, second generation. Self-decodes the format from the opcode.
//  No external immSrc is needed. Sign-extends the immediate to XLEN.

---
 rtl/imm_extend_pipe.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: decode-stage immediate generator with a registered
// valid/ready output stage (output register plus one skid register).
// The instruction format is decoded from the opcode, and the immediate is
// sign-extended to XLEN. A sideband tag travels with each instruction.
// Optional feature: define IMM_RVC_EN to decode 16-bit compressed words.
// When it is undefined, any word with instr[1:0] != 2'b11 is reported illegal.

module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_J    = 3'b011;
  localparam logic [2:0] FMT_U    = 3'b100;
  localparam logic [2:0] FMT_NONE = 3'b111;

  // Raw immediate fields in their native widths; signed so casts sign-extend
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;

  assign imm_i = in_instr[31:20];
  assign imm_s = {in_instr[31:25], in_instr[11:7]};
  assign imm_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};

`ifdef IMM_RVC_EN
  logic signed [5:0]  c_ci;
  logic signed [11:0] c_cj;
  logic signed [8:0]  c_cb;
  logic signed [17:0] c_lui;

  assign c_ci  = {in_instr[12], in_instr[6:2]};
  assign c_cj  = {in_instr[12], in_instr[8], in_instr[10:9], in_instr[6], in_instr[7],
                  in_instr[2], in_instr[11], in_instr[5:3], 1'b0};
  assign c_cb  = {in_instr[12], in_instr[6:5], in_instr[2], in_instr[11:10],
                  in_instr[4:3], 1'b0};
  assign c_lui = {in_instr[12], in_instr[6:2], 12'b0};
`endif

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  // Decode the format from the opcode and select the matching immediate
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b1;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:0])
        7'b0000011, 7'b0010011, 7'b1100111: begin
          dec_imm = XLEN'(imm_i); dec_fmt = FMT_I; dec_ill = 1'b0;
        end
        7'b0011011: begin
          if (XLEN == 64) begin
            dec_imm = XLEN'(imm_i); dec_fmt = FMT_I; dec_ill = 1'b0;
          end
        end
        7'b0100011: begin
          dec_imm = XLEN'(imm_s); dec_fmt = FMT_S; dec_ill = 1'b0;
        end
        7'b1100011: begin
          dec_imm = XLEN'(imm_b); dec_fmt = FMT_B; dec_ill = 1'b0;
        end
        7'b1101111: begin
          dec_imm = XLEN'(imm_j); dec_fmt = FMT_J; dec_ill = 1'b0;
        end
        7'b0110111, 7'b0010111: begin
          dec_imm = XLEN'(imm_u); dec_fmt = FMT_U; dec_ill = 1'b0;
        end
        7'b0110011: dec_ill = 1'b0;
        7'b0111011: begin
          if (XLEN == 64) dec_ill = 1'b0;
        end
        default: ;
      endcase
    end
`ifdef IMM_RVC_EN
    else if (in_instr[1:0] == 2'b01) begin
      case (in_instr[15:13])
        3'b000, 3'b010: begin
          dec_imm = XLEN'(c_ci); dec_fmt = FMT_I; dec_ill = 1'b0;
        end
        3'b001: begin
          // Same encoding is C.ADDIW on RV64 and C.JAL on RV32
          if (XLEN == 64) begin
            dec_imm = XLEN'(c_ci); dec_fmt = FMT_I; dec_ill = 1'b0;
          end else begin
            dec_imm = XLEN'(c_cj); dec_fmt = FMT_J; dec_ill = 1'b0;
          end
        end
        3'b101: begin
          dec_imm = XLEN'(c_cj); dec_fmt = FMT_J; dec_ill = 1'b0;
        end
        3'b110, 3'b111: begin
          dec_imm = XLEN'(c_cb); dec_fmt = FMT_B; dec_ill = 1'b0;
        end
        3'b011: begin
          if (in_instr[11:7] != 5'd2) begin
            dec_imm = XLEN'(c_lui); dec_fmt = FMT_U; dec_ill = 1'b0;
          end
        end
        default: ;
      endcase
    end
`endif
  end

  logic             or_valid, sk_valid;
  logic [XLEN-1:0]  or_imm, sk_imm;
  logic [2:0]       or_fmt, sk_fmt;
  logic             or_ill, sk_ill;
  logic [TAG_W-1:0] or_tag, sk_tag;
  logic             accept, or_free;

  assign in_ready = !reset && !sk_valid;
  assign accept   = in_valid && in_ready && !flush;
  assign or_free  = !or_valid || out_ready;

  // Occupancy of the output and skid slots; skid drains into output first
  always_ff @(posedge clk) begin
    if (reset) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else if (flush) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else if (or_free) begin
      or_valid <= sk_valid || accept;
      sk_valid <= 1'b0;
    end else if (accept) begin
      sk_valid <= 1'b1;
    end
  end

  // Output payload loads only when an entry moves in, so it holds under stall
  always_ff @(posedge clk) begin
    if (reset) begin
      or_imm <= '0;
      or_fmt <= '0;
      or_ill <= 1'b0;
      or_tag <= '0;
    end else if (!flush && or_free) begin
      if (sk_valid) begin
        or_imm <= sk_imm;
        or_fmt <= sk_fmt;
        or_ill <= sk_ill;
        or_tag <= sk_tag;
      end else if (accept) begin
        or_imm <= dec_imm;
        or_fmt <= dec_fmt;
        or_ill <= dec_ill;
        or_tag <= in_tag;
      end
    end
  end

  // Skid payload captures an accepted entry while the output slot is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      sk_imm <= '0;
      sk_fmt <= '0;
      sk_ill <= 1'b0;
      sk_tag <= '0;
    end else if (accept && !or_free) begin
      sk_imm <= dec_imm;
      sk_fmt <= dec_fmt;
      sk_ill <= dec_ill;
      sk_tag <= in_tag;
    end
  end

  assign out_valid   = or_valid;
  assign out_imm     = or_imm;
  assign out_fmt     = or_fmt;
  assign out_illegal = or_ill;
  assign out_tag     = or_tag;

endmodule
